// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences each instruction over FETCH..WRITEBACK states.
// Optional MEM_HANDSHAKE_EN: memory waits end on mem_ready instead of a fixed latency count.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic [5:0]             Funct,
  input  logic                   Zero,
  input  logic                   mem_ready,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   PCWrite,
  output logic [1:0]             RegDst,
  output logic [1:0]             MemtoReg,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [1:0]             PCSrc,
  output logic                   instr_done,
  output logic                   illegal,
  output logic [3:0]             state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JAL    = 4'd10,
    S_JR     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t     state_q;
  state_t     state_d;
  logic       mem_done;
  logic       in_wait;
  logic [2:0] alu_code;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

`ifdef MEM_HANDSHAKE_EN
  logic [31:0] unused_latency;
  assign unused_latency = MEM_LATENCY;
  assign mem_done = mem_ready;
`else
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  logic [CW-1:0] wait_cnt;
  logic          unused_ready;
  assign unused_ready = mem_ready;
  assign mem_done = (wait_cnt == CW'(MEM_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= mem_done ? '0 : wait_cnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    PCWrite    = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    alu_code   = 3'b000;
    PCSrc      = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        alu_code = 3'b100;
        if (mem_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB  = 2'b11;
        alu_code = 3'b100;
        if (OP == OP_RTYPE && Funct == FN_JR) state_d = S_JR;
        else if (OP == OP_RTYPE || OP == OP_ADDI || OP == OP_ORI || OP == OP_LUI) state_d = S_EXEC;
        else if (OP == OP_LW || OP == OP_SW) state_d = S_MEMADR;
        else if (OP == OP_BEQ || OP == OP_BNE) state_d = S_BRANCH;
        else if (OP == OP_J) state_d = S_JUMP;
        else if (OP == OP_JAL) state_d = S_JAL;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        alu_code = 3'b100;
        state_d  = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_done) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
        case (OP)
          OP_ADDI: begin ALUSrcB = 2'b10; alu_code = 3'b100; end
          OP_ORI:  begin ALUSrcB = 2'b10; alu_code = 3'b101; end
          OP_LUI:  begin ALUSrcB = 2'b10; alu_code = 3'b110; end
          default: begin ALUSrcB = 2'b00; alu_code = 3'b111; end
        endcase
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = (OP == OP_RTYPE) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        alu_code   = 3'b001;
        PCSrc      = 2'b01;
        PCWrite    = (OP == OP_BEQ) ? Zero : ~Zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC already advanced to PC+4 in FETCH, so it is the link value.
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        PCSrc      = 2'b11;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign ALUOp = ALUOP_WIDTH'(alu_code);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected control vectors queued by the driver,
// compared by a negedge monitor. Honours MEM_HANDSHAKE_EN when defined.
module tb_multicycle_control;
  localparam int AW  = 4;
  localparam int LAT = 3;
  localparam int W   = 25;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3;
  localparam logic [3:0] ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXEC = 4'd6, ST_ALUWB = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8, ST_JUMP = 4'd9, ST_JAL = 4'd10, ST_JR = 4'd11;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          IorD, MemRead, MemWrite, IRWrite, RegWrite, PCWrite;
  logic [1:0]    RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic          ALUSrcA, instr_done, illegal;
  logic [AW-1:0] ALUOp;
  logic [3:0]    state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  multicycle_control #(.ALUOP_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .OP(op), .Funct(funct), .Zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .PCWrite(PCWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] obs;
  assign obs = {state, IorD, MemRead, MemWrite, IRWrite, RegWrite, PCWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, illegal};

  task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference control vector for one cycle, written from the state table.
  function automatic logic [W-1:0] model(input logic [3:0] st, input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic d, input logic r);
    logic iord, mrd, mwr, irw, rgw, pcw, asa, idn, ill;
    logic [1:0] rdst, m2r, asb, pcs;
    logic [3:0] aop;
    logic legal;
    {iord, mrd, mwr, irw, rgw, pcw, asa, idn, ill} = '0;
    {rdst, m2r, asb, pcs} = '0;
    aop = 4'b0000;
    legal = (o == 6'h00) || (o == 6'h08) || (o == 6'h0d) || (o == 6'h0f) || (o == 6'h23) ||
            (o == 6'h2b) || (o == 6'h04) || (o == 6'h05) || (o == 6'h02) || (o == 6'h03);
    case (st)
      ST_FETCH:  begin mrd = 1; asb = 2'b01; aop = 4'b0100; irw = d; pcw = d; end
      ST_DECODE: begin asb = 2'b11; aop = 4'b0100; ill = !legal; end
      ST_MEMADR: begin asa = 1; asb = 2'b10; aop = 4'b0100; end
      ST_MEMRD:  begin mrd = 1; iord = 1; end
      ST_MEMWB:  begin rgw = 1; m2r = 2'b01; idn = 1; end
      ST_MEMWR:  begin mwr = 1; iord = 1; idn = d; end
      ST_EXEC: begin
        asa = 1;
        if (o == 6'h08)      begin asb = 2'b10; aop = 4'b0100; end
        else if (o == 6'h0d) begin asb = 2'b10; aop = 4'b0101; end
        else if (o == 6'h0f) begin asb = 2'b10; aop = 4'b0110; end
        else                 begin asb = 2'b00; aop = 4'b0111; end
      end
      ST_ALUWB:  begin rgw = 1; rdst = (o == 6'h00) ? 2'b01 : 2'b00; idn = 1; end
      ST_BRANCH: begin asa = 1; aop = 4'b0001; pcs = 2'b01; idn = 1; pcw = (o == 6'h04) ? z : !z; end
      ST_JUMP:   begin pcs = 2'b10; pcw = 1; idn = 1; end
      ST_JAL:    begin pcs = 2'b10; pcw = 1; rgw = 1; rdst = 2'b10; m2r = 2'b10; idn = 1; end
      ST_JR:     begin pcs = 2'b11; pcw = 1; idn = 1; end
      default:   ;
    endcase
    if (f == 6'h3f) ill = ill;
    if (r) begin pcw = 0; irw = 0; rgw = 0; mwr = 0; end
    return {st, iord, mrd, mwr, irw, rgw, pcw, rdst, m2r, asa, asb, aop, pcs, idn, ill};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check_val($sformatf("cycle_st%0d", e[W-1 -: 4]), obs, e);
    end
  end

  // Called at posedge+1: drive this cycle's inputs, queue its expectation, advance one cycle.
  task automatic cyc(input logic [3:0] st, input logic d, input logic rdy);
    mem_ready = rdy;
    exp_q.push_back(model(st, op, funct, zero, d, reset));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] st, input int extra);
`ifdef MEM_HANDSHAKE_EN
    for (int i = 0; i < extra; i++) cyc(st, 1'b0, 1'b0);
    cyc(st, 1'b1, 1'b1);
`else
    if (extra < 0) $display("extra ignored");
    for (int i = 0; i < LAT; i++) cyc(st, i == LAT - 1, 1'($urandom_range(0, 1)));
`endif
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int extra);
    op = o; funct = f; zero = z;
    wait_state(ST_FETCH, extra);
    cyc(ST_DECODE, 1'b0, 1'b0);
    if (o == 6'h00 && f == 6'h08) cyc(ST_JR, 1'b0, 1'b0);
    else if (o == 6'h00 || o == 6'h08 || o == 6'h0d || o == 6'h0f) begin
      cyc(ST_EXEC, 1'b0, 1'b0);
      cyc(ST_ALUWB, 1'b0, 1'b0);
    end else if (o == 6'h23) begin
      cyc(ST_MEMADR, 1'b0, 1'b0);
      wait_state(ST_MEMRD, extra);
      cyc(ST_MEMWB, 1'b0, 1'b0);
    end else if (o == 6'h2b) begin
      cyc(ST_MEMADR, 1'b0, 1'b0);
      wait_state(ST_MEMWR, extra);
    end else if (o == 6'h04 || o == 6'h05) cyc(ST_BRANCH, 1'b0, 1'b0);
    else if (o == 6'h02) cyc(ST_JUMP, 1'b0, 1'b0);
    else if (o == 6'h03) cyc(ST_JAL, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [14];
    logic [5:0] fns [3];
    ops = '{6'h00, 6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f, 6'h11, 6'h00};
    fns = '{6'h20, 6'h22, 6'h08};
    reset = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc(ST_FETCH, 1'b0, 1'b0);
    reset = 1'b0;

    run(6'h00, 6'h20, 1'b0, 0);
    run(6'h23, 6'h00, 1'b0, 0);
    run(6'h2b, 6'h00, 1'b0, 1);
    run(6'h04, 6'h00, 1'b0, 0);
    run(6'h04, 6'h00, 1'b1, 0);
    run(6'h05, 6'h00, 1'b0, 0);
    run(6'h05, 6'h00, 1'b1, 0);
    run(6'h02, 6'h00, 1'b0, 0);
    run(6'h03, 6'h00, 1'b0, 0);
    run(6'h00, 6'h08, 1'b0, 0);
    run(6'h08, 6'h00, 1'b0, 0);
    run(6'h0d, 6'h00, 1'b0, 0);
    run(6'h0f, 6'h00, 1'b0, 0);
    run(6'h3f, 6'h00, 1'b0, 0);
    run(6'h00, 6'h20, 1'b0, 5);

    // Reset asserted for two cycles in the middle of a load's memory read.
    op = 6'h23; funct = 6'h00;
    wait_state(ST_FETCH, 0);
    cyc(ST_DECODE, 1'b0, 1'b0);
    cyc(ST_MEMADR, 1'b0, 1'b0);
    cyc(ST_MEMRD, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(ST_MEMRD, 1'b0, 1'b0);
    cyc(ST_FETCH, 1'b0, 1'b0);
    reset = 1'b0;
    run(6'h23, 6'h00, 1'b0, 2);

    for (int i = 0; i < 25; i++) begin
      logic [5:0] o;
      o = ops[$urandom_range(0, 13)];
      run(o, (o == 6'h00) ? fns[$urandom_range(0, 2)] : 6'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    @(negedge clk); #1;
    check_val("queue_drained", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
